// File: rtl/gray_rd_ptr.sv
// Read-side pointer logic for an asynchronous FIFO: synchronizes the Gray write
// pointer, tracks the binary/Gray read pointer and reports empty, level and errors.
module gray_rd_ptr #(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] wptr_g,
  input  logic         rd_en,
  output logic [N-2:0] raddr,
  output logic [N-1:0] rptr_g,
  output logic         empty,
  output logic [N-1:0] level,
  output logic         uflow,
  output logic         err
);

  localparam logic [N-1:0] One   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0] Depth = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] s1_q, s2_q, s3_q;
  logic [N-1:0] rbin_q, rbin_d;
  logic [N-1:0] rptrG_q, rptrG_d;
  logic         uflow_q, uflow_d;
  logic         err_q, err_d;
  logic [N-1:0] wbin;
  logic [N-1:0] stepDiff;
  logic         readOk;
  logic         stepErr;
  logic         levelErr;
  logic         acc;

  // Only the second synchronizer stage is trusted; decode it MSB-first to binary.
  always_comb begin
    wbin = '0;
    acc  = s2_q[N-1];
    wbin[N-1] = acc;
    for (int i = N - 2; i >= 0; i--) begin
      acc     = acc ^ s2_q[i];
      wbin[i] = acc;
    end
  end

  assign empty  = (wbin == rbin_q);
  assign level  = wbin - rbin_q;
  assign readOk = rd_en & ~empty;

  assign rbin_d  = readOk ? (rbin_q + One) : rbin_q;
  assign rptrG_d = rbin_d ^ (rbin_d >> 1);

  // A legal Gray stream moves at most one bit per synchronized sample.
  assign stepDiff = s2_q ^ s3_q;
  assign stepErr  = ((stepDiff & (stepDiff - One)) != '0);
  assign levelErr = (level > Depth);

  assign uflow_d = rd_en & empty;
  assign err_d   = err_q | stepErr | levelErr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      rbin_q  <= '0;
      rptrG_q <= '0;
      uflow_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= wptr_g;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      rbin_q  <= rbin_d;
      rptrG_q <= rptrG_d;
      uflow_q <= uflow_d;
      err_q   <= err_d;
    end
  end

  assign raddr  = rbin_q[N-2:0];
  assign rptr_g = rptrG_q;
  assign uflow  = uflow_q;
  assign err    = err_q;

endmodule

// File: tb/tb_gray_rd_ptr.sv
// Scoreboard bench for gray_rd_ptr: stimulus queues expected field values for a
// given cycle, and a negedge monitor pops and compares them against the DUT.
module tb_gray_rd_ptr;

  typedef enum int {F_EMPTY, F_LEVEL, F_RPTR, F_RADDR, F_UFLOW, F_ERR} field_e;

  typedef struct {
    string      name;
    int         cyc;
    field_e     fld;
    logic [4:0] val;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [4:0] wptr_g;
  logic       rd_en;
  logic [3:0] raddr;
  logic [4:0] rptr_g;
  logic       empty;
  logic [4:0] level;
  logic       uflow;
  logic       err;

  exp_t sbQ[$];
  int   cycleCount = 0;
  int   passCount  = 0;
  int   totalChecks = 0;

  gray_rd_ptr #(.N(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .wptr_g (wptr_g),
    .rd_en  (rd_en),
    .raddr  (raddr),
    .rptr_g (rptr_g),
    .empty  (empty),
    .level  (level),
    .uflow  (uflow),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  function automatic logic [4:0] gray5(input int b);
    logic [4:0] v;
    v = b[4:0];
    return v ^ (v >> 1);
  endfunction

  task automatic checkOutput(input exp_t e);
    logic [4:0] actual;
    case (e.fld)
      F_EMPTY: actual = {4'b0, empty};
      F_LEVEL: actual = level;
      F_RPTR:  actual = rptr_g;
      F_RADDR: actual = {1'b0, raddr};
      F_UFLOW: actual = {4'b0, uflow};
      default: actual = {4'b0, err};
    endcase
    totalChecks++;
    if (actual === e.val) passCount++;
    else $display("[TB] FAIL %s (cycle %0d): got %b expected %b", e.name, e.cyc, actual, e.val);
  endtask

  // Monitor: compare every queued expectation that is due in this cycle.
  always @(negedge clk) begin
    int i;
    i = 0;
    while (i < sbQ.size()) begin
      if (sbQ[i].cyc <= cycleCount) begin
        checkOutput(sbQ[i]);
        sbQ.delete(i);
      end else begin
        i++;
      end
    end
  end

  task automatic pushExpect(input string name, input field_e fld, input logic [4:0] val, input int k);
    exp_t e;
    e.name = name;
    e.cyc  = cycleCount + k;
    e.fld  = fld;
    e.val  = val;
    sbQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic [4:0] w, input logic rd);
    rst    = r;
    wptr_g = w;
    rd_en  = rd;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expectResetState(input string tag);
    pushExpect({tag, "_empty"}, F_EMPTY, 5'd1, 0);
    pushExpect({tag, "_level"}, F_LEVEL, 5'd0, 0);
    pushExpect({tag, "_rptr"},  F_RPTR,  5'b00000, 0);
    pushExpect({tag, "_raddr"}, F_RADDR, 5'd0, 0);
    pushExpect({tag, "_err"},   F_ERR,   5'd0, 0);
    pushExpect({tag, "_uflow"}, F_UFLOW, 5'd0, 0);
  endtask

  initial begin
    applyStimulus(1'b1, 5'b00110, 1'b1);
    step(1);
    expectResetState("reset");
    applyStimulus(1'b0, 5'b00000, 1'b0);
    step(2);

    // Synchronizer latency of a single write.
    applyStimulus(1'b0, 5'b00001, 1'b0);
    pushExpect("lat_empty_e1", F_EMPTY, 5'd1, 1);
    pushExpect("lat_level_e1", F_LEVEL, 5'd0, 1);
    pushExpect("lat_empty_e2", F_EMPTY, 5'd0, 2);
    pushExpect("lat_level_e2", F_LEVEL, 5'd1, 2);
    step(2);

    // Fill to 16 entries one Gray step at a time.
    for (int b = 2; b <= 16; b++) begin
      applyStimulus(1'b0, gray5(b), 1'b0);
      step(1);
    end
    pushExpect("fill_level", F_LEVEL, 5'd16, 1);
    pushExpect("fill_empty", F_EMPTY, 5'd0, 1);
    pushExpect("fill_err",   F_ERR,   5'd0, 2);
    step(1);

    // Drain all 16, then a 17th read underflows.
    applyStimulus(1'b0, 5'b11000, 1'b1);
    pushExpect("drain_raddr0",  F_RADDR, 5'd0, 0);
    pushExpect("drain_raddr5",  F_RADDR, 5'd5, 5);
    pushExpect("drain_level8",  F_LEVEL, 5'd8, 8);
    pushExpect("drain_raddr15", F_RADDR, 5'd15, 15);
    pushExpect("drain_rptr",    F_RPTR,  5'b11000, 16);
    pushExpect("drain_empty",   F_EMPTY, 5'd1, 16);
    pushExpect("drain_level",   F_LEVEL, 5'd0, 16);
    pushExpect("drain_uflow0",  F_UFLOW, 5'd0, 16);
    pushExpect("uflow_set",     F_UFLOW, 5'd1, 17);
    pushExpect("uflow_rptr",    F_RPTR,  5'b11000, 17);
    pushExpect("uflow_level",   F_LEVEL, 5'd0, 17);
    step(17);
    applyStimulus(1'b0, 5'b11000, 1'b0);
    pushExpect("uflow_clear", F_UFLOW, 5'd0, 1);
    pushExpect("uflow_raddr", F_RADDR, 5'd0, 1);
    step(1);

    // Advance writer through the wrap, then read rbin up to 31 and past it.
    for (int b = 17; b <= 32; b++) begin
      applyStimulus(1'b0, gray5(b), 1'b0);
      step(1);
    end
    step(1);
    pushExpect("wrap_level16", F_LEVEL, 5'd16, 0);
    applyStimulus(1'b0, 5'b00000, 1'b1);
    pushExpect("wrap_rptr31",  F_RPTR,  5'b10000, 15);
    pushExpect("wrap_raddr15", F_RADDR, 5'd15, 15);
    pushExpect("wrap_level1",  F_LEVEL, 5'd1, 15);
    pushExpect("wrap_rptr0",   F_RPTR,  5'b00000, 16);
    pushExpect("wrap_raddr0",  F_RADDR, 5'd0, 16);
    pushExpect("wrap_empty",   F_EMPTY, 5'd1, 16);
    pushExpect("wrap_err",     F_ERR,   5'd0, 16);
    step(16);

    // Two-bit jump on the write pointer raises the sticky error.
    applyStimulus(1'b0, 5'b00011, 1'b0);
    pushExpect("jump_err_e2",   F_ERR,   5'd0, 2);
    pushExpect("jump_level_e2", F_LEVEL, 5'd2, 2);
    pushExpect("jump_err_e3",   F_ERR,   5'd1, 3);
    step(3);
    applyStimulus(1'b0, 5'b00111, 1'b0);
    step(1);
    applyStimulus(1'b0, 5'b00101, 1'b0);
    step(2);
    pushExpect("sticky_level6", F_LEVEL, 5'd6, 0);
    applyStimulus(1'b0, 5'b00101, 1'b1);
    pushExpect("errread_level", F_LEVEL, 5'd5, 1);
    pushExpect("errread_rptr",  F_RPTR,  5'b00001, 1);
    pushExpect("errread_raddr", F_RADDR, 5'd1, 1);
    pushExpect("errread_err",   F_ERR,   5'd1, 1);
    step(1);
    applyStimulus(1'b0, 5'b00101, 1'b0);
    pushExpect("pre_rst_level", F_LEVEL, 5'd5, 0);
    step(1);

    // Mid-operation reset: checked before the next rising edge.
    applyStimulus(1'b1, 5'b00101, 1'b0);
    expectResetState("midrst");
    step(1);
    applyStimulus(1'b0, 5'b00000, 1'b0);
    pushExpect("post_rst_level", F_LEVEL, 5'd0, 2);
    pushExpect("post_rst_empty", F_EMPTY, 5'd1, 2);
    pushExpect("post_rst_err",   F_ERR,   5'd0, 2);
    step(4);

    while (sbQ.size() > 0) begin
      totalChecks++;
      $display("[TB] FAIL %s: expectation never compared, expected %b", sbQ[0].name, sbQ[0].val);
      void'(sbQ.pop_front());
    end
    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule

// File: doc/gray_rd_ptr.md
GRAY_RD_PTR -- requirements
Module: gray_rd_ptr

Interface
REQ-001 The module SHALL have parameter N, default 5, meaning pointer width including the wrap bit, so FIFO depth is 2^(N-1).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port wptr_g, input, N bits: Gray-coded write pointer from the writer side, possibly asynchronous to clk.
REQ-005 The module SHALL have port rd_en, input, 1 bit: read request for the current entry.
REQ-006 The module SHALL have port raddr, output, N-1 bits: storage read address, equal to rbin[N-2:0].
REQ-007 The module SHALL have port rptr_g, output, N bits: registered Gray-coded read pointer returned to the writer.
REQ-008 The module SHALL have port empty, output, 1 bit: high when no unread entries exist.
REQ-009 The module SHALL have port level, output, N bits: number of unread entries.
REQ-010 The module SHALL have port uflow, output, 1 bit: registered one-cycle pulse flagging rd_en while empty.
REQ-011 The module SHALL have port err, output, 1 bit: sticky pointer-integrity error.

Function
REQ-012 wptr_g SHALL pass through a two-stage synchronizer (s1 <= wptr_g, s2 <= s1); s2 is the only version of wptr_g used internally.
REQ-013 A third register s3 <= s2 SHALL hold the previous synchronized value for step checking.
REQ-014 wbin SHALL be the combinational Gray-to-binary decode of s2: wbin[N-1] = s2[N-1], and wbin[i] = wbin[i+1] XOR s2[i] for i = N-2 down to 0.
REQ-015 The binary read pointer rbin (N bits) SHALL increment by 1, modulo 2^N, on any edge where rd_en=1 and empty=0; otherwise it holds.
REQ-016 rptr_g SHALL be registered on the same edge as rbin from the binary-to-Gray encode of next-rbin (g[N-1] = b[N-1], g[i] = b[i] XOR b[i+1]), so rptr_g always equals gray(rbin) with no extra cycle.
REQ-017 empty SHALL equal (wbin == rbin), combinational from registers.
REQ-018 level SHALL equal (wbin - rbin) mod 2^N; the legal range is 0..2^(N-1).
REQ-019 Latency: a wptr_g change SHALL be reflected in empty and level after exactly 2 rising edges.
REQ-020 Latency: a read accepted at edge k SHALL be reflected in raddr, rptr_g, empty and level immediately after edge k.
REQ-021 Underflow: rd_en=1 with empty=1 SHALL leave rbin unchanged and set uflow=1 for exactly the following cycle.
REQ-022 Pointer wrap: rbin = 2^N-1 plus an accepted read SHALL produce rbin=0; for N=5, rptr_g goes 10000 -> 00000.
REQ-023 err SHALL set on the edge after s2 differs from s3 in more than one bit position.
REQ-024 err SHALL also set on the edge after level exceeds 2^(N-1).
REQ-025 Once set, err SHALL remain 1 until reset; it SHALL NOT inhibit pointer operation.
REQ-026 A read accepted in the same cycle that s2 changes SHALL use the pre-edge values for empty; both updates take effect on that edge.

Reset
REQ-027 While rst=1, s1, s2, s3, rbin and rptr_g SHALL be 0, uflow and err SHALL be 0, empty SHALL be 1, level SHALL be 0 and raddr SHALL be 0, regardless of clk.
REQ-028 Reset asserted mid-operation SHALL clear all state immediately, including a sticky err and an in-flight synchronizer value.
REQ-029 After rst deasserts, operation SHALL resume on the first rising edge with rst=0.

Verification
REQ-030 Reset test: assert rst with wptr_g=00110 and rd_en=1 -> empty=1, level=0, rptr_g=00000, err=0, uflow=0, with no clock edge required.
REQ-031 Latency test: wptr_g steps 00000 -> 00001 -> empty stays 1 after edge 1, then empty=0 and level=1 after edge 2.
REQ-032 Fill/drain test (N=5): step wptr_g one Gray code at a time to 11000 (binary 16) -> level=16 and err=0; then hold rd_en for 16 cycles -> raddr runs 0..15, rptr_g ends at 11000, empty=1.
REQ-033 Underflow test: after the drain in REQ-032, a 17th rd_en -> uflow=1 for one cycle, rbin stays 16, level=0.
REQ-034 Wrap and error test: run rbin to 31, then one more read -> rbin=0 and rptr_g=00000; separately, jump wptr_g 00000 -> 00011 -> err=1 three edges later and err stays 1 until rst.
REQ-035 Mid-operation reset test: assert rst at level=5 with err=1 -> all outputs match REQ-027 immediately.
